axi_read_arbiter: RTL and testbench
===================================

// Module: axi_read_arbiter
// PURPOSE
//  Shares the single AXI3 read port between the instruction-cache refill controller (S0) and the
//  data-cache refill controller (S1). Allows one outstanding burst at a time. Latches the winner's
//  AR request, drives it to memory, then routes R beats back to the winner until RLAST.
//  Sits between the IF/MEM cache controllers and the memory-side AXI3 interconnect.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  R data width (matches cache refill word)
//  LEN_W   4   AXI3 ARLEN width (burst = ARLEN+1 beats)
// PORTS
//  clk            in   1       single clock; all logic posedge
//  rst            in   1       synchronous, active-high reset
//  S0_/S1_ARADDR  in   ADDR_W  requester burst start address
//  S0_/S1_ARLEN   in   LEN_W   requester burst length-1
//  S0_/S1_ARVALID in   1       requester address valid
//  S0_/S1_ARREADY out  1       address accepted (latched by arbiter)
//  S0_/S1_RDATA   out  DATA_W  routed read data
//  S0_/S1_RVALID  out  1       routed data valid
//  S0_/S1_RLAST   out  1       routed last beat
//  S0_/S1_RREADY  in   1       requester ready for data
//  M_ARADDR/M_ARLEN out ADDR_W/LEN_W  latched request to memory
//  M_ARVALID      out  1       memory address valid
//  M_ARREADY      in   1       memory address accept
//  M_RDATA        in   DATA_W  memory read data
//  M_RVALID/M_RLAST in 1       memory data valid / last beat
//  M_RREADY       out  1       arbiter ready = winner's RREADY in DATA state
//  busy           out  1       state != IDLE
//  prot_err       out  1       sticky: RLAST mismatch with latched ARLEN; cleared only by rst
// BEHAVIOUR
//  Reset (sync): state=IDLE; grant=0; last_grant=1; M_ARVALID=0; M_ARADDR=0; M_ARLEN=0;
//   beat_cnt=0; prot_err=0. All S*_ARREADY/RVALID/RLAST, M_RREADY, busy are 0 (they derive from IDLE).
//   Reset mid-burst abandons the burst. Stray beats after reset are not forwarded (M_RREADY=0 in IDLE).
//  FSM IDLE -> ADDR -> DATA -> IDLE:
//   IDLE: winner chosen combinationally from S*_ARVALID. Winner's S_ARREADY=1 in the same cycle.
//     At the edge: latch ADDR/LEN into M_ARADDR/M_ARLEN, set grant, state=ADDR, M_ARVALID<=1.
//     Loser's ARREADY=0; it must hold ARVALID/ARADDR stable (AXI rule).
//   ADDR: M_ARVALID held 1, M_ARADDR/M_ARLEN stable. On M_ARREADY: M_ARVALID<=0, beat_cnt<=0, ->DATA.
//   DATA: S_grant RDATA/RVALID/RLAST = M_* (combinational). Non-granted RVALID=0.
//     M_RREADY = S_grant RREADY. Beat = M_RVALID&M_RREADY; each beat increments beat_cnt.
//     Beat with M_RLAST: ->IDLE, last_grant<=grant. Next grant is possible on the following cycle.
//     prot_err<=1 if M_RLAST at beat_cnt!=M_ARLEN, or !M_RLAST at beat_cnt==M_ARLEN.
//     In the second case, remain in DATA until RLAST.
//  Minimum latency: S ARVALID (cycle 0) -> M_ARVALID (cycle 1). Request-to-request turnaround: 1 IDLE cycle.
//  M_R* inputs are ignored outside DATA. beat_cnt is LEN_W bits and saturates at all-ones (no wrap).
// CONFIGURATION
//  AXI_RD_ARB_RR_EN defined: round-robin. On simultaneous S0/S1 ARVALID in IDLE, grant = ~last_grant.
//  Undefined: fixed priority, S1 (D-cache) wins every tie. last_grant is still tracked but unused.
//  Single requester: that requester wins in both modes.
// STRUCTURE
//  Shared package cpu_axi_pkg: AXI3 width constants (ADDR_W, DATA_W, LEN_W);
//   arb state enum {ARB_IDLE, ARB_ADDR, ARB_DATA}.
//  One natural sub-module: axi_rd_grant (2-way priority/RR pick with last_grant register).
//  FSM, request latch, R mux and beat checker stay in the top module.
// TESTING
//  1 S0 only, ADDR=0x1000 LEN=15, M_ARREADY delayed 3 cycles
//    -> M_ARADDR=0x1000 stable while M_ARVALID high; 16 beats reach S0 only; busy falls after RLAST.
//  2 S0+S1 ARVALID same cycle, default build -> S1 granted first, S0 after S1's RLAST + 1 cycle.
//    RR build, last_grant=1 -> S0 first.
//  3 S1_RREADY low 2 cycles mid-burst (M_RVALID high) -> M_RREADY low, no beat lost or duplicated,
//    data order preserved.
//  4 LEN=3 but RLAST on beat 2 -> prot_err=1 and stays 1; FSM returns to IDLE. rst clears prot_err.
//  5 rst asserted in DATA after beat 5 -> next cycle state IDLE, all outputs at reset values.
//    M_RVALID afterwards is not forwarded.
//  6 M_RVALID asserted while in IDLE -> M_RREADY=0, S0/S1_RVALID=0.

Source files
------------

// File: rtl/cpu_axi_pkg.sv
// Shared AXI3 read-side constants and the read-arbiter state encoding.
package cpu_axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_LEN_W  = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/axi_rd_grant.sv
// Two-way read-request pick. AXI_RD_ARB_RR_EN selects round-robin tie-break;
// otherwise requester 1 (D-cache) wins every tie.
module axi_rd_grant (
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  input  logic upd_i,
  input  logic upd_grant_i,
  output logic win_o
);

`ifdef AXI_RD_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  logic last_grant_q;
  logic last_grant_d;
  logic tie_pick_s;

  // last_grant is tracked in both modes; only round-robin consults it
  assign tie_pick_s = RR_EN ? ~last_grant_q : 1'b1;
  assign win_o      = req1_i & (~req0_i | tie_pick_s);

  // Record the requester whose burst just completed
  always_comb begin
    if (upd_i) begin
      last_grant_d = upd_grant_i;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  // Last-grant register
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI3 read port between I-cache (S0) and D-cache (S1) refills, one burst at a time.
// Define AXI_RD_ARB_RR_EN for round-robin tie-break (default: S1 wins ties).
module axi_read_arbiter
  import cpu_axi_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int LEN_W  = AXI_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] S0_ARADDR,
  input  logic [LEN_W-1:0]  S0_ARLEN,
  input  logic              S0_ARVALID,
  output logic              S0_ARREADY,
  output logic [DATA_W-1:0] S0_RDATA,
  output logic              S0_RVALID,
  output logic              S0_RLAST,
  input  logic              S0_RREADY,
  input  logic [ADDR_W-1:0] S1_ARADDR,
  input  logic [LEN_W-1:0]  S1_ARLEN,
  input  logic              S1_ARVALID,
  output logic              S1_ARREADY,
  output logic [DATA_W-1:0] S1_RDATA,
  output logic              S1_RVALID,
  output logic              S1_RLAST,
  input  logic              S1_RREADY,
  output logic [ADDR_W-1:0] M_ARADDR,
  output logic [LEN_W-1:0]  M_ARLEN,
  output logic              M_ARVALID,
  input  logic              M_ARREADY,
  input  logic [DATA_W-1:0] M_RDATA,
  input  logic              M_RVALID,
  input  logic              M_RLAST,
  output logic              M_RREADY,
  output logic              busy,
  output logic              prot_err
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] m_araddr_q, m_araddr_d;
  logic [LEN_W-1:0]  m_arlen_q, m_arlen_d;
  logic              m_arvalid_q, m_arvalid_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              prot_err_q, prot_err_d;

  logic win_s;
  logic lg_upd_s;
  logic in_idle_s;
  logic in_data_s;
  logic beat_s;

  axi_rd_grant u_grant (
    .clk         (clk),
    .rst         (rst),
    .req0_i      (S0_ARVALID),
    .req1_i      (S1_ARVALID),
    .upd_i       (lg_upd_s),
    .upd_grant_i (grant_q),
    .win_o       (win_s)
  );

  assign in_idle_s = (state_q == ARB_IDLE);
  assign in_data_s = (state_q == ARB_DATA);

  assign S0_ARREADY = in_idle_s & S0_ARVALID & ~win_s;
  assign S1_ARREADY = in_idle_s & S1_ARVALID & win_s;

  // R channel is steered to the granted requester only while a burst is in DATA
  assign S0_RDATA  = M_RDATA;
  assign S1_RDATA  = M_RDATA;
  assign S0_RVALID = in_data_s & ~grant_q & M_RVALID;
  assign S1_RVALID = in_data_s & grant_q & M_RVALID;
  assign S0_RLAST  = in_data_s & ~grant_q & M_RLAST;
  assign S1_RLAST  = in_data_s & grant_q & M_RLAST;
  assign M_RREADY  = in_data_s & (grant_q ? S1_RREADY : S0_RREADY);
  assign beat_s    = M_RVALID & M_RREADY;

  assign M_ARADDR  = m_araddr_q;
  assign M_ARLEN   = m_arlen_q;
  assign M_ARVALID = m_arvalid_q;
  assign busy      = ~in_idle_s;
  assign prot_err  = prot_err_q;

  // Next-state, request latch and beat/RLAST consistency check
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    m_araddr_d  = m_araddr_q;
    m_arlen_d   = m_arlen_q;
    m_arvalid_d = m_arvalid_q;
    beat_cnt_d  = beat_cnt_q;
    prot_err_d  = prot_err_q;
    lg_upd_s    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (S0_ARVALID | S1_ARVALID) begin
          grant_d     = win_s;
          m_araddr_d  = win_s ? S1_ARADDR : S0_ARADDR;
          m_arlen_d   = win_s ? S1_ARLEN : S0_ARLEN;
          m_arvalid_d = 1'b1;
          state_d     = ARB_ADDR;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ADDR: begin
        if (M_ARREADY) begin
          m_arvalid_d = 1'b0;
          beat_cnt_d  = '0;
          state_d     = ARB_DATA;
        end else begin
          state_d = ARB_ADDR;
        end
      end
      ARB_DATA: begin
        if (beat_s) begin
          beat_cnt_d = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + LEN_W'(1);
          if (M_RLAST) begin
            if (beat_cnt_q != m_arlen_q) begin
              prot_err_d = 1'b1;
            end else begin
              prot_err_d = prot_err_q;
            end
            lg_upd_s = 1'b1;
            state_d  = ARB_IDLE;
          end else begin
            // Missing RLAST: flag it but keep forwarding until memory ends the burst
            if (beat_cnt_q == m_arlen_q) begin
              prot_err_d = 1'b1;
            end else begin
              prot_err_d = prot_err_q;
            end
            state_d = ARB_DATA;
          end
        end else begin
          state_d = ARB_DATA;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      grant_q     <= 1'b0;
      m_araddr_q  <= '0;
      m_arlen_q   <= '0;
      m_arvalid_q <= 1'b0;
      beat_cnt_q  <= '0;
      prot_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      m_araddr_q  <= m_araddr_d;
      m_arlen_q   <= m_arlen_d;
      m_arvalid_q <= m_arvalid_d;
      beat_cnt_q  <= beat_cnt_d;
      prot_err_q  <= prot_err_d;
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: expected R beats are queued per requester
// by the stimulus and consumed by a negedge monitor.
module tb_axi_read_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] S0_ARADDR, S1_ARADDR, M_ARADDR;
  logic [3:0]  S0_ARLEN, S1_ARLEN, M_ARLEN;
  logic        S0_ARVALID, S1_ARVALID, S0_ARREADY, S1_ARREADY;
  logic [31:0] S0_RDATA, S1_RDATA, M_RDATA;
  logic        S0_RVALID, S1_RVALID, S0_RLAST, S1_RLAST, S0_RREADY, S1_RREADY;
  logic        M_ARVALID, M_ARREADY, M_RVALID, M_RLAST, M_RREADY;
  logic        busy, prot_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ready_cyc[2];
  int last_cyc[2];
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .S0_ARADDR(S0_ARADDR), .S0_ARLEN(S0_ARLEN), .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
    .S0_RDATA(S0_RDATA), .S0_RVALID(S0_RVALID), .S0_RLAST(S0_RLAST), .S0_RREADY(S0_RREADY),
    .S1_ARADDR(S1_ARADDR), .S1_ARLEN(S1_ARLEN), .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
    .S1_RDATA(S1_RDATA), .S1_RVALID(S1_RVALID), .S1_RLAST(S1_RLAST), .S1_RREADY(S1_RREADY),
    .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RVALID(M_RVALID), .M_RLAST(M_RLAST), .M_RREADY(M_RREADY),
    .busy(busy), .prot_err(prot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait expired, got no event, expected one (t=%0t)", name, $time);
  endtask

  task automatic exp_push(input int s, input logic [31:0] base, input int n, input int last_idx);
    for (int i = 0; i < n; i++) begin
      logic [32:0] e;
      e = {(i == last_idx), base + 32'(i)};
      if (s == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  // Requester side: raise ARVALID and hold it until the arbiter accepts
  task automatic s_req(input int s, input logic [31:0] addr, input logic [3:0] len);
    bit got;
    got = 1'b0;
    if (s == 0) begin S0_ARVALID = 1'b1; S0_ARADDR = addr; S0_ARLEN = len; end
    else begin S1_ARVALID = 1'b1; S1_ARADDR = addr; S1_ARLEN = len; end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((s == 0 && S0_ARREADY) || (s == 1 && S1_ARREADY)) begin
        got = 1'b1;
        ready_cyc[s] = cyc;
        break;
      end
    end
    if (!got) timeout_fail("ar_ready_timeout");
    @(posedge clk); #1;
    if (s == 0) S0_ARVALID = 1'b0;
    else S1_ARVALID = 1'b0;
  endtask

  // Memory side: accept the AR after ar_delay stall cycles, then return nbeats beats
  task automatic mem_serve(input logic [31:0] addr, input logic [3:0] len, input int nbeats,
                           input int last_idx, input int ar_delay, input logic [31:0] base);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (M_ARVALID) begin got = 1'b1; break; end
    end
    if (!got) begin
      timeout_fail("m_arvalid_timeout");
      return;
    end
    check("m_araddr", M_ARADDR, addr);
    check("m_arlen", M_ARLEN, len);
    for (int d = 0; d < ar_delay; d++) begin
      @(negedge clk);
      check("ar_hold_valid", M_ARVALID, 1'b1);
      check("ar_hold_addr", M_ARADDR, addr);
    end
    M_ARREADY = 1'b1;
    @(posedge clk); #1;
    M_ARREADY = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      M_RVALID = 1'b1;
      M_RDATA  = base + 32'(i);
      M_RLAST  = (i == last_idx);
      got = 1'b0;
      for (int w = 0; w < 100; w++) begin
        @(negedge clk);
        if (i == 0 && w == 0) check("ar_dropped", M_ARVALID, 1'b0);
        if (M_RREADY) begin got = 1'b1; break; end
      end
      if (!got) begin
        timeout_fail("m_rready_timeout");
        break;
      end
      @(posedge clk); #1;
    end
    M_RVALID = 1'b0;
    M_RLAST  = 1'b0;
    if (last_idx >= 0) begin
      @(negedge clk);
      check("busy_after_rlast", busy, 1'b0);
    end
  endtask

  // Monitor: every beat the DUT presents must match the head of that requester's queue
  always @(negedge clk) begin
    if (!rst) begin
      if (S0_RVALID) begin
        if (q0.size() == 0) begin
          tests++; fails++;
          $display("FAIL s0_unexpected_beat: got data 0x%0h, expected no beat (t=%0t)", S0_RDATA, $time);
        end else if (S0_RREADY) begin
          logic [32:0] e;
          e = q0.pop_front();
          check("s0_rdata", S0_RDATA, e[31:0]);
          check("s0_rlast", S0_RLAST, e[32]);
          if (e[32]) last_cyc[0] = cyc;
        end
      end
      if (S1_RVALID) begin
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL s1_unexpected_beat: got data 0x%0h, expected no beat (t=%0t)", S1_RDATA, $time);
        end else if (S1_RREADY) begin
          logic [32:0] e;
          e = q1.pop_front();
          check("s1_rdata", S1_RDATA, e[31:0]);
          check("s1_rlast", S1_RLAST, e[32]);
          if (e[32]) last_cyc[1] = cyc;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int second;
    rst = 1'b1;
    S0_ARADDR = 32'h0; S0_ARLEN = 4'h0; S0_ARVALID = 1'b0; S0_RREADY = 1'b1;
    S1_ARADDR = 32'h0; S1_ARLEN = 4'h0; S1_ARVALID = 1'b0; S1_RREADY = 1'b1;
    M_ARREADY = 1'b0; M_RDATA = 32'h0; M_RVALID = 1'b0; M_RLAST = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_m_arvalid", M_ARVALID, 1'b0);
    check("rst_m_araddr", M_ARADDR, 32'h0);
    check("rst_m_arlen", M_ARLEN, 4'h0);
    check("rst_prot_err", prot_err, 1'b0);
    check("rst_m_rready", M_RREADY, 1'b0);
    check("rst_arready", {S0_ARREADY, S1_ARREADY}, 2'b00);

    // Test 6: stray R beat while IDLE
    @(posedge clk); #1;
    M_RVALID = 1'b1; M_RLAST = 1'b1; M_RDATA = 32'hDEAD_BEEF;
    repeat (2) begin
      @(negedge clk);
      check("idle_m_rready", M_RREADY, 1'b0);
      check("idle_rvalid", {S0_RVALID, S1_RVALID}, 2'b00);
      check("idle_busy", busy, 1'b0);
    end
    @(posedge clk); #1;
    M_RVALID = 1'b0; M_RLAST = 1'b0;

    // Test 2: simultaneous requests straight after reset (last_grant = 1)
`ifdef AXI_RD_ARB_RR_EN
    first = 0;
`else
    first = 1;
`endif
    second = 1 - first;
    @(posedge clk); #1;
    fork
      s_req(0, 32'h0000_2000, 4'd2);
      s_req(1, 32'h0000_3000, 4'd1);
      begin
        if (first == 1) begin
          exp_push(1, 32'h1100_0000, 2, 1);
          mem_serve(32'h0000_3000, 4'd1, 2, 1, 0, 32'h1100_0000);
          exp_push(0, 32'h0100_0000, 3, 2);
          mem_serve(32'h0000_2000, 4'd2, 3, 2, 0, 32'h0100_0000);
        end else begin
          exp_push(0, 32'h0100_0000, 3, 2);
          mem_serve(32'h0000_2000, 4'd2, 3, 2, 0, 32'h0100_0000);
          exp_push(1, 32'h1100_0000, 2, 1);
          mem_serve(32'h0000_3000, 4'd1, 2, 1, 0, 32'h1100_0000);
        end
      end
    join
    check("tie_turnaround", 32'(ready_cyc[second] - last_cyc[first]), 32'd1);
    check("tie_order", (ready_cyc[first] < ready_cyc[second]), 1'b1);

    // Test 1: S0 alone, 16-beat burst, AR accepted after 3 stall cycles
    @(posedge clk); #1;
    fork
      s_req(0, 32'h0000_1000, 4'd15);
      begin
        exp_push(0, 32'h5000_0000, 16, 15);
        mem_serve(32'h0000_1000, 4'd15, 16, 15, 3, 32'h5000_0000);
      end
    join
    check("t1_prot_err", prot_err, 1'b0);

    // Test 3: S1 back-pressure for 2 cycles mid-burst
    @(posedge clk); #1;
    fork
      s_req(1, 32'h0000_4000, 4'd7);
      begin
        exp_push(1, 32'h7700_0000, 8, 7);
        mem_serve(32'h0000_4000, 4'd7, 8, 7, 0, 32'h7700_0000);
      end
      begin
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
          @(posedge clk);
          if (q1.size() <= 5) begin got = 1'b1; break; end
        end
        if (!got) timeout_fail("t3_progress_timeout");
        #1 S1_RREADY = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("stall_m_rready", M_RREADY, 1'b0);
          check("stall_m_rvalid", M_RVALID, 1'b1);
        end
        @(posedge clk); #1 S1_RREADY = 1'b1;
      end
    join
    check("t3_prot_err", prot_err, 1'b0);

    // Test 4: LEN=3 but RLAST on the third beat; error is sticky across a clean burst
    @(posedge clk); #1;
    fork
      s_req(0, 32'h0000_6000, 4'd3);
      begin
        exp_push(0, 32'h6600_0000, 3, 2);
        mem_serve(32'h0000_6000, 4'd3, 3, 2, 1, 32'h6600_0000);
      end
    join
    check("t4_prot_err_set", prot_err, 1'b1);
    check("t4_idle", busy, 1'b0);
    @(posedge clk); #1;
    fork
      s_req(1, 32'h0000_6800, 4'd0);
      begin
        exp_push(1, 32'h6800_0000, 1, 0);
        mem_serve(32'h0000_6800, 4'd0, 1, 0, 0, 32'h6800_0000);
      end
    join
    check("t4_prot_err_sticky", prot_err, 1'b1);

    // Test 5: reset after 5 beats of a 16-beat burst
    @(posedge clk); #1;
    fork
      s_req(0, 32'h0000_8000, 4'd15);
      begin
        exp_push(0, 32'h8800_0000, 5, -1);
        mem_serve(32'h0000_8000, 4'd15, 5, -1, 0, 32'h8800_0000);
      end
    join
    check("t5_busy_before_rst", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_busy", busy, 1'b0);
    check("t5_m_arvalid", M_ARVALID, 1'b0);
    check("t5_m_araddr", M_ARADDR, 32'h0);
    check("t5_m_arlen", M_ARLEN, 4'h0);
    check("t5_prot_err", prot_err, 1'b0);
    check("t5_m_rready", M_RREADY, 1'b0);
    @(posedge clk); #1;
    M_RVALID = 1'b1; M_RDATA = 32'h8800_0005; M_RLAST = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t5_stray_m_rready", M_RREADY, 1'b0);
      check("t5_stray_rvalid", {S0_RVALID, S1_RVALID}, 2'b00);
    end
    @(posedge clk); #1;
    M_RVALID = 1'b0;

    repeat (2) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
